uart_out_queue: RTL and testbench

- Buffered, parametrised successor to the core's single-byte UART output path.
- Accepts words of up to DATA_BYTES bytes, with a per-word byte count, from the execution stage.
- Queues them in a DEPTH-entry FIFO and drains them byte-by-byte, LSB first, to the AXI4-lite UART Lite.
- Performs its own status polling (STAT_REG 0x8) and TX_FIFO (0x4) writes, so the core never stalls on TX-full.

---
 rtl/uart_out_queue.sv | 201 ++++++++++++++++++++
 tb/tb_uart_out_queue.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_out_queue.sv
// Buffered multi-byte UART output queue: DEPTH-entry FIFO drained LSB-first to an AXI4-lite UART Lite.
// Optional UART_OUT_BURST_EN: a TX-empty status grants 16 writes without re-polling.
module uart_out_queue #(
  parameter int DATA_BYTES = 4,
  parameter int DEPTH      = 16,
  parameter int CNT_W      = $clog2(DEPTH) + 1,
  parameter int LEN_W      = $clog2(DATA_BYTES) + 1
) (
  input  logic                    clk,
  input  logic                    rstn,
  input  logic [8*DATA_BYTES-1:0] in_data,
  input  logic [LEN_W-1:0]        in_nbytes,
  input  logic                    in_valid,
  output logic                    in_ready,
  output logic [CNT_W-1:0]        count,
  output logic                    busy,
  output logic                    err,
  output logic [3:0]              uart_axi_araddr,
  output logic                    uart_axi_arvalid,
  input  logic                    uart_axi_arready,
  input  logic [31:0]             uart_axi_rdata,
  input  logic [1:0]              uart_axi_rresp,
  input  logic                    uart_axi_rvalid,
  output logic                    uart_axi_rready,
  output logic [3:0]              uart_axi_awaddr,
  output logic                    uart_axi_awvalid,
  input  logic                    uart_axi_awready,
  output logic [31:0]             uart_axi_wdata,
  output logic [3:0]              uart_axi_wstrb,
  output logic                    uart_axi_wvalid,
  input  logic                    uart_axi_wready,
  input  logic [1:0]              uart_axi_bresp,
  input  logic                    uart_axi_bvalid,
  output logic                    uart_axi_bready,
  output logic [2:0]              dbg_state
);

  localparam int                AW       = $clog2(DEPTH);
  localparam logic [LEN_W-1:0] MAX_LEN  = LEN_W'(DATA_BYTES);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_RD_STAT   = 3'd1,
    S_WAIT_STAT = 3'd2,
    S_WR        = 3'd3,
    S_WAIT_B    = 3'd4,
    S_POP       = 3'd5
  } state_t;

  state_t                  r_state, w_next_state;
  logic [8*DATA_BYTES-1:0] r_mem_data [DEPTH];
  logic [LEN_W-1:0]        r_mem_len  [DEPTH];
  logic [AW-1:0]           r_wr_ptr, r_rd_ptr;
  logic [CNT_W-1:0]        r_count;
  logic [LEN_W-1:0]        r_byte_idx;
  logic                    r_aw_done, r_w_done, r_err;

  logic                    w_push, w_pop;
  logic [LEN_W-1:0]        w_len_clamped, w_head_len, w_idx_inc;
  logic [8*DATA_BYTES-1:0] w_head_data, w_head_shifted;
  logic                    w_aw_fire, w_w_fire, w_wr_done;
  logic                    w_r_fire, w_b_fire, w_last_byte;
  logic                    w_skip_poll_idle, w_skip_poll_b, w_load_credit;
  logic                    w_unused;

  // Push acceptance looks only at the registered count, so a same-cycle pop never frees a slot.
  assign in_ready      = (r_count != FULL_CNT);
  assign w_push        = in_valid & in_ready;
  assign w_pop         = (r_state == S_POP);
  assign w_len_clamped = (in_nbytes > MAX_LEN) ? MAX_LEN : in_nbytes;

  assign w_head_data    = r_mem_data[r_rd_ptr];
  assign w_head_len     = r_mem_len[r_rd_ptr];
  assign w_head_shifted = w_head_data >> {r_byte_idx, 3'b000};
  assign w_idx_inc      = r_byte_idx + 1'b1;
  assign w_last_byte    = (w_idx_inc == w_head_len);

  assign w_aw_fire = uart_axi_awvalid & uart_axi_awready;
  assign w_w_fire  = uart_axi_wvalid & uart_axi_wready;
  assign w_wr_done = (r_aw_done | w_aw_fire) & (r_w_done | w_w_fire);
  assign w_r_fire  = (r_state == S_WAIT_STAT) & uart_axi_rvalid;
  assign w_b_fire  = (r_state == S_WAIT_B) & uart_axi_bvalid;
  assign w_load_credit = w_r_fire & (uart_axi_rresp == 2'b00) & ~uart_axi_rdata[3]
                         & uart_axi_rdata[2];

`ifdef UART_OUT_BURST_EN
  logic [4:0] r_credit;
  logic [4:0] w_credit_after;

  assign w_credit_after   = ((uart_axi_bresp != 2'b00) || (r_credit == 5'd0)) ? 5'd0
                                                                              : r_credit - 5'd1;
  assign w_skip_poll_idle = (r_credit != 5'd0);
  assign w_skip_poll_b    = (w_credit_after != 5'd0);

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_credit <= 5'd0;
    end else if (w_r_fire && uart_axi_rresp != 2'b00) begin
      r_credit <= 5'd0;
    end else if (w_load_credit) begin
      r_credit <= 5'd16;
    end else if (w_b_fire) begin
      r_credit <= w_credit_after;
    end
  end
`else
  assign w_skip_poll_idle = 1'b0;
  assign w_skip_poll_b    = 1'b0;
`endif

  assign w_unused = ^{uart_axi_rdata, w_head_shifted, w_load_credit};

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE: begin
        if (r_count != '0) begin
          if (w_head_len == '0)   w_next_state = S_POP;
          else if (w_skip_poll_idle) w_next_state = S_WR;
          else                    w_next_state = S_RD_STAT;
        end
      end
      S_RD_STAT:   if (uart_axi_arready) w_next_state = S_WAIT_STAT;
      S_WAIT_STAT: begin
        if (uart_axi_rvalid) begin
          if (uart_axi_rresp != 2'b00) w_next_state = S_RD_STAT;
          else if (uart_axi_rdata[3])  w_next_state = S_RD_STAT;
          else                         w_next_state = S_WR;
        end
      end
      S_WR:        if (w_wr_done) w_next_state = S_WAIT_B;
      S_WAIT_B: begin
        if (uart_axi_bvalid) begin
          if (w_last_byte)        w_next_state = S_POP;
          else if (w_skip_poll_b) w_next_state = S_WR;
          else                    w_next_state = S_RD_STAT;
        end
      end
      S_POP:       w_next_state = S_IDLE;
      default:     w_next_state = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem_data[r_wr_ptr] <= in_data;
      r_mem_len[r_wr_ptr]  <= w_len_clamped;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state    <= S_IDLE;
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_byte_idx <= '0;
      r_aw_done  <= 1'b0;
      r_w_done   <= 1'b0;
      r_err      <= 1'b0;
    end else begin
      r_state <= w_next_state;
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      if (r_state == S_IDLE) r_byte_idx <= '0;
      else if (w_b_fire)     r_byte_idx <= w_idx_inc;
      // AW and W channels complete independently; remember which one already handshook.
      if (r_state == S_WR && !w_wr_done) begin
        r_aw_done <= r_aw_done | w_aw_fire;
        r_w_done  <= r_w_done | w_w_fire;
      end else begin
        r_aw_done <= 1'b0;
        r_w_done  <= 1'b0;
      end
      if ((w_r_fire && uart_axi_rresp != 2'b00) || (w_b_fire && uart_axi_bresp != 2'b00))
        r_err <= 1'b1;
    end
  end

  assign count     = r_count;
  assign busy      = (r_count != '0) | (r_state != S_IDLE);
  assign err       = r_err;
  assign dbg_state = r_state;

  assign uart_axi_araddr  = 4'h8;
  assign uart_axi_arvalid = (r_state == S_RD_STAT);
  assign uart_axi_rready  = (r_state == S_WAIT_STAT);
  assign uart_axi_awaddr  = 4'h4;
  assign uart_axi_awvalid = (r_state == S_WR) & ~r_aw_done;
  assign uart_axi_wvalid  = (r_state == S_WR) & ~r_w_done;
  assign uart_axi_wdata   = {24'b0, w_head_shifted[7:0]};
  assign uart_axi_wstrb   = 4'b0001;
  assign uart_axi_bready  = (r_state == S_WAIT_B);

endmodule

// File: tb/tb_uart_out_queue.sv
// Directed bench for uart_out_queue: negedge slave model logs TX writes, main sequence checks them.
module tb_uart_out_queue;
  logic        clk = 1'b0;
  logic        rstn = 1'b0;
  logic [31:0] in_data;
  logic [2:0]  in_nbytes;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  count;
  logic        busy, err;
  logic [3:0]  uart_axi_araddr, uart_axi_awaddr, uart_axi_wstrb;
  logic        uart_axi_arvalid, uart_axi_arready, uart_axi_rvalid, uart_axi_rready;
  logic [31:0] uart_axi_rdata, uart_axi_wdata;
  logic [1:0]  uart_axi_rresp, uart_axi_bresp;
  logic        uart_axi_awvalid, uart_axi_awready, uart_axi_wvalid, uart_axi_wready;
  logic        uart_axi_bvalid, uart_axi_bready;
  logic [2:0]  dbg_state;

  uart_out_queue dut (
    .clk(clk), .rstn(rstn), .in_data(in_data), .in_nbytes(in_nbytes),
    .in_valid(in_valid), .in_ready(in_ready), .count(count), .busy(busy), .err(err),
    .uart_axi_araddr(uart_axi_araddr), .uart_axi_arvalid(uart_axi_arvalid),
    .uart_axi_arready(uart_axi_arready), .uart_axi_rdata(uart_axi_rdata),
    .uart_axi_rresp(uart_axi_rresp), .uart_axi_rvalid(uart_axi_rvalid),
    .uart_axi_rready(uart_axi_rready), .uart_axi_awaddr(uart_axi_awaddr),
    .uart_axi_awvalid(uart_axi_awvalid), .uart_axi_awready(uart_axi_awready),
    .uart_axi_wdata(uart_axi_wdata), .uart_axi_wstrb(uart_axi_wstrb),
    .uart_axi_wvalid(uart_axi_wvalid), .uart_axi_wready(uart_axi_wready),
    .uart_axi_bresp(uart_axi_bresp), .uart_axi_bvalid(uart_axi_bvalid),
    .uart_axi_bready(uart_axi_bready), .dbg_state(dbg_state)
  );

  // clock / reset
  always #5 clk = ~clk;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // scoreboard state
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] exp_q[$];
  logic [31:0] wr_q[$];
  int          wr_cyc_q[$];
  int          rd_cnt = 0, ar_cnt = 0, b_cnt = 0;
  int          full_until = 0;
  int          bad_b = -1;

  // slave responses: status busy while rd_cnt < full_until, error bresp on write number bad_b
  always @(negedge clk) begin
    if (rstn) begin
      uart_axi_rdata = (rd_cnt < full_until) ? 32'h8 : 32'h0;
      if (uart_axi_rvalid && uart_axi_rready) rd_cnt++;
      if (uart_axi_arvalid && uart_axi_arready) ar_cnt++;
      if (uart_axi_wvalid && uart_axi_wready) begin
        wr_q.push_back(uart_axi_wdata);
        wr_cyc_q.push_back(cyc);
      end
      uart_axi_bresp = (b_cnt == bad_b) ? 2'b10 : 2'b00;
      if (uart_axi_bvalid && uart_axi_bready) b_cnt++;
    end
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  // driver tasks
  task automatic push(input logic [31:0] d, input logic [2:0] nb, output bit ok);
    @(negedge clk);
    in_data = d; in_nbytes = nb; in_valid = 1'b1;
    ok = in_ready;
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_idle(input string tag, input int max_cyc);
    bit ok = 1'b0;
    for (int i = 0; i < max_cyc; i++) begin
      @(negedge clk);
      if (!busy) begin ok = 1'b1; break; end
    end
    check({tag, "_drain_done"}, 64'(ok), 64'd1);
  endtask

  task automatic check_writes(input string tag);
    int n = exp_q.size();
    check({tag, "_nwrites"}, 64'(wr_q.size()), 64'(n));
    for (int i = 0; i < n; i++)
      check($sformatf("%s_wdata%0d", tag, i), (i < wr_q.size()) ? 64'(wr_q[i]) : 64'hx,
            64'(exp_q[i]));
    exp_q.delete(); wr_q.delete(); wr_cyc_q.delete();
  endtask

  initial begin
    bit ok;
    int c0, a0, r0, n_ok;
    in_data = '0; in_nbytes = '0; in_valid = 1'b0;
    uart_axi_arready = 1'b1; uart_axi_rvalid = 1'b1; uart_axi_rresp = 2'b00;
    uart_axi_rdata = 32'h0;  uart_axi_awready = 1'b1; uart_axi_wready = 1'b1;
    uart_axi_bvalid = 1'b1;  uart_axi_bresp = 2'b00;

    // reset state
    repeat (3) @(negedge clk);
    check("rst_count", 64'(count), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_busy", 64'(busy), 64'd0);
    check("rst_err", 64'(err), 64'd0);
    check("rst_valids", 64'({uart_axi_arvalid, uart_axi_rready, uart_axi_awvalid,
                             uart_axi_wvalid, uart_axi_bready}), 64'd0);
    check("rst_state", 64'(dbg_state), 64'd0);
    rstn = 1'b1;

    // 1: four bytes LSB first, 4 cycles per byte, POP then idle
    push(32'h44332211, 3'd4, ok);
    c0 = cyc;
    check("t1_accept", 64'(ok), 64'd1);
    check("t1_count1", 64'(count), 64'd1);
    check("t1_arvalid_low", 64'(uart_axi_arvalid), 64'd0);
    @(negedge clk);
    check("t1_arvalid", 64'(uart_axi_arvalid), 64'd1);
    check("t1_araddr", 64'(uart_axi_araddr), 64'h8);
    repeat (2) @(negedge clk);
    check("t1_aw_w_together", 64'({uart_axi_awvalid, uart_axi_wvalid}), 64'h3);
    check("t1_awaddr", 64'(uart_axi_awaddr), 64'h4);
    check("t1_wstrb", 64'(uart_axi_wstrb), 64'h1);
    wait_idle("t1", 100);
    check("t1_idle_cycle", 64'(cyc - c0), 64'd18);
    check("t1_count0", 64'(count), 64'd0);
    for (int i = 0; i < 4; i++)
      check($sformatf("t1_wr_cycle%0d", i), 64'((i < wr_cyc_q.size()) ? wr_cyc_q[i] - c0 : -1),
            64'(3 + 4 * i));
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44};
    check_writes("t1");

    // 2: status full three times, then empty
    full_until = rd_cnt + 3; r0 = rd_cnt; a0 = ar_cnt;
    push(32'h000000AB, 3'd1, ok);
    wait_idle("t2", 200);
    check("t2_status_reads", 64'(rd_cnt - r0), 64'd4);
    check("t2_ar_handshakes", 64'(ar_cnt - a0), 64'd4);
    exp_q = '{32'hAB};
    check_writes("t2");

    // 3: fill with stalled slave, refuse 17th, then drain in order
    uart_axi_arready = 1'b0; n_ok = 0;
    for (int i = 0; i < 16; i++) begin
      push(32'h40 + 32'(i), 3'd1, ok);
      if (ok) n_ok++;
      exp_q.push_back(32'h40 + 32'(i));
    end
    check("t3_accepted", 64'(n_ok), 64'd16);
    check("t3_count_full", 64'(count), 64'd16);
    check("t3_in_ready_low", 64'(in_ready), 64'd0);
    push(32'hEE, 3'd1, ok);
    check("t3_refused", 64'(ok), 64'd0);
    check("t3_count_still_full", 64'(count), 64'd16);
    uart_axi_arready = 1'b1;
    wait_idle("t3", 1000);
    check_writes("t3");

    // 4: zero-length entry between two 2-byte entries, then an over-long nbytes clamped to 4
    a0 = ar_cnt;
    push(32'h00002211, 3'd2, ok);
    push(32'hDEADBEEF, 3'd0, ok);
    push(32'h00004433, 3'd2, ok);
    push(32'h88776655, 3'd7, ok);
    wait_idle("t4", 300);
    check("t4_ar_handshakes", 64'(ar_cnt - a0), 64'd8);
    exp_q = '{32'h11, 32'h22, 32'h33, 32'h44, 32'h55, 32'h66, 32'h77, 32'h88};
    check_writes("t4");

    // 5: bresp error on second byte is sticky, no retry
    check("t5_err_before", 64'(err), 64'd0);
    bad_b = b_cnt + 1;
    push(32'h04030201, 3'd4, ok);
    wait_idle("t5", 200);
    check("t5_err_set", 64'(err), 64'd1);
    exp_q = '{32'h01, 32'h02, 32'h03, 32'h04};
    check_writes("t5a");
    bad_b = -1;
    push(32'h00000099, 3'd1, ok);
    wait_idle("t5b", 100);
    check("t5_err_sticky", 64'(err), 64'd1);
    exp_q = '{32'h99};
    check_writes("t5b");

    // 6: asynchronous reset while a write is pending
    uart_axi_awready = 1'b0; uart_axi_wready = 1'b0;
    push(32'hAA, 3'd1, ok);
    push(32'hBB, 3'd1, ok);
    push(32'hCC, 3'd1, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (uart_axi_awvalid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("t6_awvalid_seen", 64'(ok), 64'd1);
    check("t6_count_pre", 64'(count), 64'd3);
    #2 rstn = 1'b0;
    #1;
    check("t6_aw_w_dropped", 64'({uart_axi_awvalid, uart_axi_wvalid}), 64'd0);
    check("t6_count", 64'(count), 64'd0);
    check("t6_state", 64'(dbg_state), 64'd0);
    check("t6_busy_err", 64'({busy, err}), 64'd0);
    check("t6_in_ready", 64'(in_ready), 64'd1);
    uart_axi_awready = 1'b1; uart_axi_wready = 1'b1;
    @(negedge clk);
    rstn = 1'b1;
    wr_q.delete(); wr_cyc_q.delete(); exp_q.delete();
    push(32'h0000005A, 3'd1, ok);
    wait_idle("t6", 100);
    exp_q = '{32'h5A};
    check_writes("t6");

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
